// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// data-memory stage. Data wins contention until fetch has been denied
// MAX_WAIT times in a row; then fetch is forced through. Read responses are
// routed back to their owner using a MEM_LAT-deep tag pipeline.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  // Tag owner encoding: 1 = data port, 0 = fetch port.
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [MEM_LAT-1:0] tag_valid_q, tag_valid_d;
  logic [MEM_LAT-1:0] tag_owner_q, tag_owner_d;
  logic               if_win, dm_win;

  // Arbitration and memory-side outputs; everything forced idle during reset.
  always_comb begin
    if_win      = 1'b0;
    dm_win      = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!rst) begin
      if_win = if_req_i && (!dm_req_i || (starve_cnt_q == MAX_CNT));
      dm_win = dm_req_i && !if_win;
    end
    if (if_win) begin
      mem_re_o   = 1'b1;
      mem_addr_o = if_addr_i;
    end else if (dm_win) begin
      mem_re_o    = !dm_we_i;
      mem_we_o    = dm_we_i;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end
    if_gnt_o = if_win;
    dm_gnt_o = dm_win;
  end

  // Starvation counter: counts consecutive cycles fetch was denied by data.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_i || if_win) begin
      starve_cnt_d = '0;
    end else if (dm_win && (starve_cnt_q != MAX_CNT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Tag pipeline: stage 0 takes the current grant, older tags shift toward
  // the last stage, which lines up with mem_rdata_i.
  always_comb begin
    tag_valid_d    = '0;
    tag_owner_d    = '0;
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_owner_d[i] = tag_owner_q[i-1];
    end
    tag_valid_d[0] = mem_re_o;
    tag_owner_d[0] = dm_win;
  end

  // State registers; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      tag_valid_q  <= '0;
      tag_owner_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_valid_q  <= tag_valid_d;
      tag_owner_q  <= tag_owner_d;
    end
  end

  // Response steering: data passes through, rvalid goes to the tag owner.
  always_comb begin
    if_rvalid_o = !rst && tag_valid_q[MEM_LAT-1] && !tag_owner_q[MEM_LAT-1];
    dm_rvalid_o = !rst && tag_valid_q[MEM_LAT-1] &&  tag_owner_q[MEM_LAT-1];
    if_rdata_o  = mem_rdata_i;
    dm_rdata_o  = mem_rdata_i;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share the same
// stimulus and differ only in MEM_LAT (index 0 -> 1, 1 -> 2, 2 -> 3).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic        if_gnt [3];
  logic        if_rvalid [3];
  logic [31:0] if_rdata [3];
  logic        dm_gnt [3];
  logic        dm_rvalid [3];
  logic [31:0] dm_rdata [3];
  logic        mem_re [3];
  logic        mem_we [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(gi + 1), .MAX_WAIT(3)
      ) u_dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[gi]),
        .if_rvalid_o(if_rvalid[gi]), .if_rdata_o(if_rdata[gi]),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
        .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt[gi]),
        .dm_rvalid_o(dm_rvalid[gi]), .dm_rdata_o(dm_rdata[gi]),
        .mem_re_o(mem_re[gi]), .mem_we_o(mem_we[gi]),
        .mem_addr_o(mem_addr[gi]), .mem_wdata_o(mem_wdata[gi]),
        .mem_rdata_i(mem_rdata)
      );
    end
  endgenerate

  // Advance to the start of the next cycle (just after the rising edge).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 0; dm_req = 0; dm_we = 0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    rst = 1; if_req = 1; dm_req = 1; dm_we = 0;
    if_addr = 32'h40; dm_addr = 32'h200; dm_wdata = 32'h0; mem_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #1;
      for (int d = 0; d < 3; d++) begin
        nvec++;
        if ({if_gnt[d], dm_gnt[d], if_rvalid[d], dm_rvalid[d], mem_re[d], mem_we[d]} !== 6'b0
            || mem_addr[d] !== 32'h0 || mem_wdata[d] !== 32'h0) begin
          nerr++;
          $display("FAIL reset_idle dut%0d cyc%0d: gnt/rv/strobes=%b addr=%h wdata=%h, want all 0",
                   d, c, {if_gnt[d], dm_gnt[d], if_rvalid[d], dm_rvalid[d], mem_re[d], mem_we[d]},
                   mem_addr[d], mem_wdata[d]);
        end
      end
    end
    next_cycle();
    rst = 0;
    #1;
    nvec++;
    if (dm_gnt[0] !== 1'b1 || if_gnt[0] !== 1'b0 || mem_addr[0] !== 32'h200) begin
      nerr++;
      $display("FAIL reset_release: dm_gnt=%b if_gnt=%b addr=%h, want 1 0 00000200",
               dm_gnt[0], if_gnt[0], mem_addr[0]);
    end
    $display("reset: released, first grant checked");
    idle(5);
  endtask

  task automatic test_fetch_read();
    if_req = 1; if_addr = 32'h40; dm_req = 0;
    #1;
    nvec++;
    if (if_gnt[0] !== 1'b1 || mem_re[0] !== 1'b1 || mem_we[0] !== 1'b0 || mem_addr[0] !== 32'h40) begin
      nerr++;
      $display("FAIL fetch_grant: gnt=%b re=%b we=%b addr=%h, want 1 1 0 00000040",
               if_gnt[0], mem_re[0], mem_we[0], mem_addr[0]);
    end
    next_cycle();
    if_req = 0; mem_rdata = 32'h1234_5678;
    #1;
    nvec++;
    if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== 32'h1234_5678 || dm_rvalid[0] !== 1'b0) begin
      nerr++;
      $display("FAIL fetch_resp: if_rvalid=%b rdata=%h dm_rvalid=%b, want 1 12345678 0",
               if_rvalid[0], if_rdata[0], dm_rvalid[0]);
    end
    next_cycle();
    #1;
    nvec++;
    if (if_rvalid[0] !== 1'b0) begin
      nerr++;
      $display("FAIL fetch_resp_once: if_rvalid=%b, want 0", if_rvalid[0]);
    end
    $display("fetch_read: addr 0x40 lat1 checked");
    idle(5);
  endtask

  task automatic test_starvation();
    logic [7:0] want_if;
    want_if = 8'b1000_1000; // bit c: fetch wins in cycle c
    if_req = 1; dm_req = 1; dm_we = 0; if_addr = 32'h80; dm_addr = 32'h300;
    for (int c = 0; c < 8; c++) begin
      #1;
      nvec++;
      if (if_gnt[0] !== want_if[c] || dm_gnt[0] !== !want_if[c]) begin
        nerr++;
        $display("FAIL starve cyc%0d: if_gnt=%b dm_gnt=%b, want %b %b",
                 c, if_gnt[0], dm_gnt[0], want_if[c], !want_if[c]);
      end
      next_cycle();
    end
    $display("starvation: 8 contended cycles checked");
    idle(6);
  endtask

  task automatic test_pipelined();
    // cycles 0..3 grant D-read, F-read, D-write, F-read; responses on DUT 1 (lat 2)
    logic [5:0] want_dm, want_if;
    want_dm = 6'b000100;
    want_if = 6'b101000;
    for (int c = 0; c < 6; c++) begin
      if_req = (c == 1 || c == 3);
      dm_req = (c == 0 || c == 2);
      dm_we  = (c == 2);
      if_addr = 32'h1000 + 32'(c); dm_addr = 32'h2000 + 32'(c); dm_wdata = 32'hA5A5_0000;
      mem_rdata = 32'hC0DE_0000 + 32'(c);
      #1;
      nvec++;
      if (if_gnt[1] !== if_req || dm_gnt[1] !== dm_req || mem_we[1] !== (c == 2)) begin
        nerr++;
        $display("FAIL pipe_gnt cyc%0d: if_gnt=%b dm_gnt=%b we=%b", c, if_gnt[1], dm_gnt[1], mem_we[1]);
      end
      nvec++;
      if (dm_rvalid[1] !== want_dm[c] || if_rvalid[1] !== want_if[c]) begin
        nerr++;
        $display("FAIL pipe_rvalid cyc%0d: dm=%b if=%b, want %b %b",
                 c, dm_rvalid[1], if_rvalid[1], want_dm[c], want_if[c]);
      end
      if (want_if[c] || want_dm[c]) begin
        nvec++;
        if ((want_if[c] ? if_rdata[1] : dm_rdata[1]) !== 32'hC0DE_0000 + 32'(c)) begin
          nerr++;
          $display("FAIL pipe_rdata cyc%0d: if=%h dm=%h, want %h",
                   c, if_rdata[1], dm_rdata[1], 32'hC0DE_0000 + 32'(c));
        end
      end
      next_cycle();
    end
    $display("pipelined: D-rd F-rd D-wr F-rd lat2 checked");
    idle(5);
  endtask

  task automatic test_write();
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; if_req = 0;
    #1;
    nvec++;
    if (mem_we[0] !== 1'b1 || mem_re[0] !== 1'b0 || mem_wdata[0] !== 32'hDEAD_BEEF
        || mem_addr[0] !== 32'h100 || dm_gnt[0] !== 1'b1) begin
      nerr++;
      $display("FAIL write: we=%b re=%b wdata=%h addr=%h gnt=%b, want 1 0 deadbeef 00000100 1",
               mem_we[0], mem_re[0], mem_wdata[0], mem_addr[0], dm_gnt[0]);
    end
    next_cycle();
    dm_req = 0; dm_we = 0;
    for (int c = 1; c < 6; c++) begin
      #1;
      for (int d = 0; d < 3; d++) begin
        nvec++;
        if (dm_rvalid[d] !== 1'b0 || if_rvalid[d] !== 1'b0) begin
          nerr++;
          $display("FAIL write_noresp dut%0d cyc%0d: dm_rvalid=%b if_rvalid=%b, want 0 0",
                   d, c, dm_rvalid[d], if_rvalid[d]);
        end
      end
      next_cycle();
    end
    $display("write: 0xDEADBEEF to 0x100 checked");
  endtask

  task automatic test_reset_midflight();
    // Two contended cycles raise starve_cnt to 2; cycle 0 (also contended,
    // data read) takes it to 3, so without a clear fetch would win later.
    if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h400; if_addr = 32'h44;
    next_cycle();
    next_cycle();
    #1;
    nvec++;
    if (dm_gnt[2] !== 1'b1 || mem_re[2] !== 1'b1) begin
      nerr++;
      $display("FAIL midrst_grant: dm_gnt=%b re=%b, want 1 1", dm_gnt[2], mem_re[2]);
    end
    next_cycle();
    rst = 1;                    // cycle 1
    for (int c = 1; c < 7; c++) begin
      if (c == 2) begin
        rst = 0; dm_we = 1;     // contended write: must go to data
        #1;
        nvec++;
        if (dm_gnt[2] !== 1'b1 || if_gnt[2] !== 1'b0) begin
          nerr++;
          $display("FAIL midrst_starve_clr: dm_gnt=%b if_gnt=%b, want 1 0", dm_gnt[2], if_gnt[2]);
        end
      end else if (c == 3) begin
        if_req = 0; dm_req = 0; dm_we = 0;
      end
      #1;
      nvec++;
      if (dm_rvalid[2] !== 1'b0 || if_rvalid[2] !== 1'b0) begin
        nerr++;
        $display("FAIL midrst_drop cyc%0d: dm_rvalid=%b if_rvalid=%b, want 0 0",
                 c, dm_rvalid[2], if_rvalid[2]);
      end
      next_cycle();
    end
    $display("reset_midflight: lat3 in-flight read dropped");
  endtask

  initial begin
    rst = 1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    #1;
    test_reset();
    test_fetch_read();
    test_starvation();
    test_pipelined();
    test_write();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
